// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial packed-BCD adder.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Added to a binary digit sum above 9 to wrap it back into decimal range.
  localparam bcd_digit_t BCD_CORR = 4'd6;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input bcd_digit_t nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Request/result bundle between the operand front end and the serial BCD adder.
interface bcd_serial_adder_ctrl_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic [4*DIGITS-1:0]   a_bcd;
  logic [4*DIGITS-1:0]   b_bcd;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum_bcd;
  logic                  cout;
  logic                  err;

  // Requester side: drives operands, observes status and result.
  modport master (
    output start, a_bcd, b_bcd, cin,
    input  busy, done, sum_bcd, cout, err
  );

  // Adder side: consumes operands, drives status and result.
  modport slave (
    input  start, a_bcd, b_bcd, cin,
    output busy, done, sum_bcd, cout, err
  );

endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder with +6 correction; purely combinational.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t digit,
  output logic       co
);

  logic [4:0] sum_bin;
  logic [4:0] sum_corr;

  // Binary sum, then wrap into decimal range when it exceeds 9.
  always_comb begin
    sum_bin  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    sum_corr = sum_bin + {1'b0, BCD_CORR};
    digit    = sum_bin[3:0];
    co       = 1'b0;
    if (sum_bin > 5'd9) begin
      digit = sum_corr[3:0];
      co    = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Sequencer that adds two packed-BCD operands one digit per clock through a
// single shared digit adder, rippling the decimal carry through a register.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bcd_serial_adder_ctrl_if.slave        bus
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            c_q, c_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic            err_acc_q, err_acc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  bcd_digit_t      dig_a, dig_b, dig_sum;
  logic            dig_co;

  // Select the operand digits addressed by the current index.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
  end

  bcd_digit_add u_digit_add (
    .a     (dig_a),
    .b     (dig_b),
    .ci    (c_q),
    .digit (dig_sum),
    .co    (dig_co)
  );

  // Next-state and datapath updates for the IDLE -> ADD -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    c_d       = c_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    err_acc_d = err_acc_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    err_d     = err_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d       = bus.a_bcd;
          b_d       = bus.b_bcd;
          c_d       = bus.cin;
          idx_d     = '0;
          work_d    = '0;
          err_acc_d = 1'b0;
          state_d   = ADD;
        end
      end
      ADD: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDXW'(i)) begin
            work_d[4*i +: 4] = dig_sum;
          end
        end
        c_d       = dig_co;
        err_acc_d = err_acc_q | ~is_bcd(dig_a) | ~is_bcd(dig_b);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        sum_d   = work_q;
        cout_d  = c_q;
        err_d   = err_acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy mirrors the registered state so it is free of input paths.
    busy_d = (state_d == ADD);
  end

  // State, datapath and output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      c_q       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      err_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      c_q       <= c_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_q    <= work_d;
      err_acc_q <= err_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum_bcd = sum_q;
  assign bus.cout    = cout_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for the serial BCD adder: a 4-digit and a 1-digit instance.
module tb_bcd_serial_adder_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_serial_adder_ctrl_if #(.DIGITS(D)) bus4 ();
  bcd_serial_adder_ctrl_if #(.DIGITS(1)) bus1 ();

  bcd_serial_adder_ctrl #(.DIGITS(D)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  bcd_serial_adder_ctrl #(.DIGITS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on the 4-digit instance with cycle-exact status checks.
  // glitch_k >= 0 raises start with other operands at that negedge for one edge.
  task automatic run_op(input string tag,
                        input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic [15:0] exp_sum, input logic exp_cout,
                        input logic exp_err, input int glitch_k);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a_bcd = a;
    bus4.b_bcd = b;
    bus4.cin   = ci;
    @(posedge clk);
    for (int k = 0; k <= D + 3; k++) begin
      @(negedge clk);
      if (k < D) begin
        check({tag, "_busy"}, 32'(bus4.busy), 32'd1);
        check({tag, "_nodone"}, 32'(bus4.done), 32'd0);
      end else if (k == D) begin
        check({tag, "_busy_end"}, 32'(bus4.busy), 32'd0);
        check({tag, "_done_early"}, 32'(bus4.done), 32'd0);
      end else if (k == D + 1) begin
        check({tag, "_done"}, 32'(bus4.done), 32'd1);
        check({tag, "_busy_done"}, 32'(bus4.busy), 32'd0);
        check({tag, "_sum"}, 32'(bus4.sum_bcd), 32'(exp_sum));
        check({tag, "_cout"}, 32'(bus4.cout), 32'(exp_cout));
        check({tag, "_err"}, 32'(bus4.err), 32'(exp_err));
      end else begin
        check({tag, "_done_drop"}, 32'(bus4.done), 32'd0);
        check({tag, "_sum_hold"}, 32'(bus4.sum_bcd), 32'(exp_sum));
      end
      if (k == 0) begin
        bus4.start = 1'b0;
        bus4.a_bcd = 16'h0000;
        bus4.b_bcd = 16'h0000;
      end
      if (k == glitch_k) begin
        bus4.start = 1'b1;
        bus4.a_bcd = 16'h1111;
        bus4.b_bcd = 16'h1111;
        bus4.cin   = 1'b1;
      end
      if (k == glitch_k + 1) begin
        bus4.start = 1'b0;
        bus4.cin   = 1'b0;
      end
    end
    $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d err=%0d",
             tag, a, b, ci, bus4.sum_bcd, bus4.cout, bus4.err);
  endtask

  initial begin
    int nd;
    int next_exp;

    bus4.start = 1'b0; bus4.a_bcd = '0; bus4.b_bcd = '0; bus4.cin = 1'b0;
    bus1.start = 1'b0; bus1.a_bcd = '0; bus1.b_bcd = '0; bus1.cin = 1'b0;

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_done", 32'(bus4.done), 32'd0);
    check("rst_sum", 32'(bus4.sum_bcd), 32'd0);
    check("rst_cout", 32'(bus4.cout), 32'd0);
    check("rst_err", 32'(bus4.err), 32'd0);
    rst_n = 1'b1;
    $display("reset released");

    run_op("basic",  16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, -10);
    run_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, -10);
    run_op("max",    16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, -10);
    run_op("cin",    16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, -10);
    run_op("badnib", 16'h12A4, 16'h0001, 1'b0, 16'h1305, 1'b0, 1'b1, -10);
    run_op("clrerr", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, -10);
    // start raised again two edges into the operation must be ignored.
    run_op("ignore", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1);

    // Reset mid-operation clears outputs at once and suppresses done.
    @(negedge clk);
    bus4.start = 1'b1; bus4.a_bcd = 16'h4444; bus4.b_bcd = 16'h4444;
    @(posedge clk);
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus4.busy), 32'd0);
    check("abort_done", 32'(bus4.done), 32'd0);
    check("abort_sum", 32'(bus4.sum_bcd), 32'd0);
    check("abort_cout", 32'(bus4.cout), 32'd0);
    check("abort_err", 32'(bus4.err), 32'd0);
    $display("reset asserted mid-operation");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_nodone", 32'(bus4.done), 32'd0);
    end
    run_op("after_rst", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, -10);

    // start held high: accepted at E0, E6, E12, E18; done at E5, E11, E17, E23.
    @(negedge clk);
    bus4.start = 1'b1; bus4.a_bcd = 16'h0001; bus4.b_bcd = 16'h0001; bus4.cin = 1'b0;
    nd = 0;
    next_exp = 5;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 19) bus4.start = 1'b0;
      if (bus4.done === 1'b1) begin
        check("held_cycle", 32'(c), 32'(next_exp));
        check("held_sum", 32'(bus4.sum_bcd), 32'h0002);
        $display("held done at cycle %0d sum=%h", c, bus4.sum_bcd);
        next_exp += 6;
        nd++;
      end
    end
    check("held_count", 32'(nd), 32'd4);

    // One-digit instance: 9+9+1 = 19 -> digit 9, carry out, done after 2 edges.
    @(negedge clk);
    bus1.start = 1'b1; bus1.a_bcd = 4'h9; bus1.b_bcd = 4'h9; bus1.cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    check("d1_busy", 32'(bus1.busy), 32'd1);
    check("d1_nodone", 32'(bus1.done), 32'd0);
    @(negedge clk);
    check("d1_busy_end", 32'(bus1.busy), 32'd0);
    check("d1_done_early", 32'(bus1.done), 32'd0);
    @(negedge clk);
    check("d1_done", 32'(bus1.done), 32'd1);
    check("d1_sum", 32'(bus1.sum_bcd), 32'h9);
    check("d1_cout", 32'(bus1.cout), 32'd1);
    check("d1_err", 32'(bus1.err), 32'd0);
    $display("d1 a=9 b=9 cin=1 -> sum=%h cout=%0d", bus1.sum_bcd, bus1.cout);
    @(negedge clk);
    check("d1_done_drop", 32'(bus1.done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
